// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the sequential binary-to-BCD converter.
// Provides the control-state enum, the nibble width and a sizing function
// that returns the number of decimal digits a given input width needs.
package bcd_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    // Digits needed to hold the largest magnitude: 2^bin_w-1 unsigned,
    // 2^(bin_w-1) signed (the most negative value has the largest magnitude).
    function automatic int bcd_digits_needed(input int bin_w, input bit is_signed);
        longint max_mag;
        longint p;
        int n;
        max_mag = is_signed ? (64'sd1 <<< (bin_w - 1)) : ((64'sd1 <<< bin_w) - 64'sd1);
        n = 1;
        p = 10;
        while (p <= max_mag) begin
            p = p * 10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// bcd_nibble_adj: double-dabble digit corrector, adds 3 to a nibble above 4.
// Ports: d - current BCD nibble; q - corrected nibble (truncated to 4 bits).
module bcd_nibble_adj
    import bcd_pkg::*;
(
    input  logic [NIB_W-1:0] d,
    output logic [NIB_W-1:0] q
);

    always_comb q = (d > 4'd4) ? d + 4'd3 : d;

endmodule

// File: rtl/bcd_converter_seq.sv
// bcd_converter_seq: sequential shift-and-add-3 binary-to-BCD converter, one shift per clock.
// Ports: clk/reset (async active-low); in_valid/in_ready/bin_in accept side;
// out_valid/out_ready/bcd_out/blank_mask/neg result side; busy high while shifting.
module bcd_converter_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 13,
    parameter int DIGITS = 4,
    parameter int SIGNED = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NIB_W*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]       blank_mask,
    output logic                    neg,
    output logic                    busy
);

    localparam int BCD_W = NIB_W * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < 2) begin : g_bad_width
        $error("bcd_converter_seq: BIN_W must be at least 2");
    end
    if (DIGITS < bcd_digits_needed(BIN_W, SIGNED != 0)) begin : g_bad_digits
        $error("bcd_converter_seq: DIGITS too small for BIN_W/SIGNED");
    end

    state_e            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [DIGITS-1:0] mask_q, mask_d;
    logic              sign_q, sign_d;
    logic              neg_q, neg_d;

    logic [BCD_W-1:0]  adj;
    logic [SR_W-1:0]   shifted;
    logic [BIN_W-1:0]  mag;
    logic [DIGITS-1:0] zmask;
    logic              all_zero;
    logic              last;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_nibble_adj u_adj (
            .d(sr_q[BIN_W+NIB_W*i +: NIB_W]),
            .q(adj[NIB_W*i +: NIB_W])
        );
    end

    always_comb shifted = {adj, sr_q[BIN_W-1:0]} << 1;

    // Negating the BIN_W-bit pattern maps -2^(BIN_W-1) onto 2^(BIN_W-1) unsigned.
    always_comb mag = (SIGNED != 0 && bin_in[BIN_W-1]) ? -bin_in : bin_in;

    always_comb last = cnt_q == CNT_W'(BIN_W - 1);

    // Leading-zero mask from the top digit down; digit 0 is never blanked.
    always_comb begin
        zmask = '0;
        all_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            all_zero = all_zero & (shifted[BIN_W+NIB_W*k +: NIB_W] == '0);
            zmask[k] = all_zero;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        mask_d  = mask_q;
        sign_d  = sign_q;
        neg_d   = neg_q;
        if (state_q == IDLE && in_valid) begin
            sr_d    = {{BCD_W{1'b0}}, mag};
            cnt_d   = '0;
            sign_d  = (SIGNED != 0) && bin_in[BIN_W-1] && (mag != '0);
            state_d = SHIFT;
        end else if (state_q == SHIFT) begin
            sr_d  = shifted;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                bcd_d   = shifted[SR_W-1 -: BCD_W];
                mask_d  = zmask;
                neg_d   = sign_q;
                state_d = DONE;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            mask_q  <= '0;
            sign_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            mask_q  <= mask_d;
            sign_q  <= sign_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign busy       = state_q == SHIFT;
    assign bcd_out    = bcd_q;
    assign blank_mask = mask_q;
    assign neg        = neg_q;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// tb_bcd_converter_seq: scoreboard bench for the unsigned (13b/4d) and signed (8b/3d) converters.
module tb_bcd_converter_seq;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  mask;
        logic        neg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, neg, busy;
    logic [12:0] bin_in = '0;
    logic [15:0] bcd_out;
    logic [3:0]  blank_mask;

    logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1, s_neg, s_busy;
    logic [7:0]  s_bin_in = '0;
    logic [11:0] s_bcd_out;
    logic [2:0]  s_blank_mask;

    exp_t q[$];
    exp_t sq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bcd_converter_seq #(.BIN_W(13), .DIGITS(4), .SIGNED(0)) u_dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
        .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out),
        .blank_mask(blank_mask), .neg(neg), .busy(busy)
    );

    bcd_converter_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u_sdut (
        .clk(clk), .reset(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .bin_in(s_bin_in),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .bcd_out(s_bcd_out),
        .blank_mask(s_blank_mask), .neg(s_neg), .busy(s_busy)
    );

    // Reference digits by repeated division.
    function automatic logic [15:0] model_bcd(input int m);
        logic [15:0] r;
        int t;
        r = '0;
        t = m;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference mask from the count of significant decimal digits.
    function automatic logic [3:0] model_mask(input int m, input int digits);
        logic [3:0] r;
        int nd;
        int t;
        nd = 1;
        t = m;
        while (t >= 10) begin
            t = t / 10;
            nd++;
        end
        r = '0;
        for (int k = 0; k < digits; k++) r[k] = (k >= nd);
        return r;
    endfunction

    task automatic send(input int v);
        exp_t e;
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bin_in = 13'(v);
        in_valid = 1'b1;
        e.bcd = model_bcd(v);
        e.mask = model_mask(v, 4);
        e.neg = 1'b0;
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic s_send(input logic [7:0] v);
        exp_t e;
        int sv;
        int m;
        int n;
        n = 0;
        while (!s_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        sv = int'($signed(v));
        m = sv < 0 ? -sv : sv;
        s_bin_in = v;
        s_in_valid = 1'b1;
        e.bcd = model_bcd(m);
        e.mask = model_mask(m, 3);
        e.neg = sv < 0;
        sq.push_back(e);
        @(negedge clk);
        s_in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen; 999 if the bound expires.
    task automatic wait_out(input bit sgn, output int cyc);
        cyc = 0;
        while (!(sgn ? s_out_valid : out_valid) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!(sgn ? s_out_valid : out_valid)) cyc = 999;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, busy, bcd_out, blank_mask, neg} !== {1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_unsigned: got rdy=%b vld=%b busy=%b bcd=%h mask=%b neg=%b",
                     in_ready, out_valid, busy, bcd_out, blank_mask, neg);
        end
        n_cmp++;
        if ({s_in_ready, s_out_valid, s_busy, s_bcd_out, s_blank_mask, s_neg} !== {1'b1, 1'b0, 1'b0, 12'h0, 3'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_signed: got rdy=%b vld=%b busy=%b bcd=%h mask=%b neg=%b",
                     s_in_ready, s_out_valid, s_busy, s_bcd_out, s_blank_mask, s_neg);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_scale;
        exp_t e;
        int cyc;
        send(8191);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_in_shift: got %b expected 1", busy);
        end
        wait_out(1'b0, cyc);
        n_cmp++;
        if (cyc != 13) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles expected 13", cyc);
        end
        e = q.pop_front();
        n_cmp++;
        if ({bcd_out, blank_mask, neg} !== {e.bcd, e.mask, e.neg}) begin
            n_bad++;
            $display("FAIL full_scale: got bcd=%h mask=%b neg=%b expected bcd=%h mask=%b neg=%b",
                     bcd_out, blank_mask, neg, e.bcd, e.mask, e.neg);
        end
    endtask

    task automatic test_small_zero;
        exp_t e;
        int cyc;
        int vals[2] = '{7, 0};
        foreach (vals[j]) begin
            send(vals[j]);
            wait_out(1'b0, cyc);
            e = q.pop_front();
            n_cmp++;
            if (cyc != 13 || {bcd_out, blank_mask, neg} !== {e.bcd, e.mask, e.neg}) begin
                n_bad++;
                $display("FAIL small_%0d: got bcd=%h mask=%b neg=%b cyc=%0d expected bcd=%h mask=%b neg=0 cyc=13",
                         vals[j], bcd_out, blank_mask, neg, cyc, e.bcd, e.mask);
            end
        end
    endtask

    task automatic test_signed;
        exp_t e;
        int cyc;
        logic [7:0] vals[5] = '{8'h80, 8'hFF, 8'h7F, 8'h00, 8'hF6};
        foreach (vals[j]) begin
            s_send(vals[j]);
            wait_out(1'b1, cyc);
            e = sq.pop_front();
            n_cmp++;
            if (cyc != 8 || {s_bcd_out, s_blank_mask, s_neg} !== {e.bcd[11:0], e.mask[2:0], e.neg}) begin
                n_bad++;
                $display("FAIL signed_%h: got bcd=%h mask=%b neg=%b cyc=%0d expected bcd=%h mask=%b neg=%b cyc=8",
                         vals[j], s_bcd_out, s_blank_mask, s_neg, cyc, e.bcd[11:0], e.mask[2:0], e.neg);
            end
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        int cyc;
        out_ready = 1'b0;
        send(4321);
        wait_out(1'b0, cyc);
        e = q.pop_front();
        n_cmp++;
        if (cyc != 13 || bcd_out !== e.bcd) begin
            n_bad++;
            $display("FAIL bp_result: got bcd=%h cyc=%0d expected bcd=%h cyc=13", bcd_out, cyc, e.bcd);
        end
        for (int j = 0; j < 20; j++) begin
            in_valid = 1'b1;
            bin_in = 13'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready, busy, bcd_out, blank_mask} !== {1'b1, 1'b0, 1'b0, e.bcd, e.mask}) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b busy=%b bcd=%h mask=%b expected vld=1 rdy=0 busy=0 bcd=%h mask=%b",
                         j, out_valid, in_ready, busy, bcd_out, blank_mask, e.bcd, e.mask);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, bcd_out} !== {1'b1, 1'b0, e.bcd}) begin
            n_bad++;
            $display("FAIL bp_release: got rdy=%b vld=%b bcd=%h expected rdy=1 vld=0 bcd=%h",
                     in_ready, out_valid, bcd_out, e.bcd);
        end
        send(555);
        wait_out(1'b0, cyc);
        e = q.pop_front();
        n_cmp++;
        if (cyc != 13 || {bcd_out, blank_mask} !== {e.bcd, e.mask}) begin
            n_bad++;
            $display("FAIL bp_next: got bcd=%h mask=%b cyc=%0d expected bcd=%h mask=%b cyc=13",
                     bcd_out, blank_mask, cyc, e.bcd, e.mask);
        end
    endtask

    task automatic test_reset_mid_shift;
        exp_t e;
        int cyc;
        @(negedge clk);
        send(100);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(q.pop_front());
        n_cmp++;
        if ({in_ready, out_valid, busy, bcd_out, blank_mask, neg} !== {1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_mid_shift: got rdy=%b vld=%b busy=%b bcd=%h mask=%b neg=%b",
                     in_ready, out_valid, busy, bcd_out, blank_mask, neg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1234);
        wait_out(1'b0, cyc);
        e = q.pop_front();
        n_cmp++;
        if (cyc != 13 || bcd_out !== e.bcd || bcd_out !== 16'h1234) begin
            n_bad++;
            $display("FAIL after_reset: got bcd=%h cyc=%0d expected bcd=%h cyc=13", bcd_out, cyc, e.bcd);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int next;
        int got;
        int cyc;
        int last_t;
        @(negedge clk);
        out_ready = 1'b1;
        next = 0;
        got = 0;
        cyc = 0;
        last_t = -1;
        while (got < 101 && cyc < 2500) begin
            if (out_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_extra: got bcd=%h with no result expected", bcd_out);
                end else begin
                    e = q.pop_front();
                    if ({bcd_out, blank_mask, neg} !== {e.bcd, e.mask, e.neg}) begin
                        n_bad++;
                        $display("FAIL b2b_value_%0d: got bcd=%h mask=%b expected bcd=%h mask=%b",
                                 got, bcd_out, blank_mask, e.bcd, e.mask);
                    end
                end
                if (last_t >= 0) begin
                    n_cmp++;
                    if (cyc - last_t != 15) begin
                        n_bad++;
                        $display("FAIL b2b_spacing_%0d: got %0d cycles expected 15", got, cyc - last_t);
                    end
                end
                last_t = cyc;
                got++;
            end
            if (in_ready && next <= 100) begin
                bin_in = 13'(next);
                in_valid = 1'b1;
                e.bcd = model_bcd(next);
                e.mask = model_mask(next, 4);
                e.neg = 1'b0;
                q.push_back(e);
                next++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got != 101) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d results expected 101", got);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_full_scale();
        test_small_zero();
        test_signed();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_converter_seq.md
# bcd_converter_seq

Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one shift per clock. It adds valid/ready handshakes on both sides, an optional two's-complement signed mode, and a leading-zero blanking mask. It sits between score and timer counters and the seven-segment display multiplexer. Each conversion is triggered explicitly, never by input change detection.

## Interface
- `BIN_W`, default 13: width of the binary input; minimum 2.
- `DIGITS`, default 4: number of BCD output digits. Elaboration fails unless 10^DIGITS > maximum magnitude (2^BIN_W−1 unsigned, 2^(BIN_W−1) signed).
- `SIGNED`, default 0: 1 = input is two's complement; the magnitude is converted and the sign is reported separately.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `bin_in` is valid.
- `in_ready`  output  1  converter can accept a value.
- `bin_in`  input  BIN_W  binary value.
- `out_valid`  output  1  result is valid.
- `out_ready`  input  1  consumer accepts the result.
- `bcd_out`  output  4*DIGITS  BCD digits; digit 0 (units) is in bits [3:0].
- `blank_mask`  output  DIGITS  bit i = 1 means digit i is a leading zero.
- `neg`  output  1  result is negative (SIGNED=1 only; tied 0 otherwise).
- `busy`  output  1  conversion in progress.

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, load the shift register as {4*DIGITS zeros, magnitude}, clear the shift counter, capture `neg`, and go to SHIFT.
- **Magnitude:**
  - SIGNED=0: `bin_in`.
  - SIGNED=1 with `bin_in` MSB=1: −`bin_in` taken as BIN_W-bit unsigned. −2^(BIN_W−1) maps correctly to 2^(BIN_W−1).
- **SHIFT, each cycle:**
  - Every BCD nibble > 4 gets +3, truncated to 4 bits.
  - Then the whole register shifts left by 1 and the counter increments.
  - After the BIN_W-th shift, go to DONE.
- **Shift register width:** 4*DIGITS+BIN_W bits. The BCD field is the upper 4*DIGITS bits.
- **DONE:**
  - `out_valid`=1. `bcd_out`, `blank_mask` and `neg` are registered and stable.
  - On `out_ready`, go to IDLE.
- **`blank_mask`:**
  - Computed from the final digits when entering DONE.
  - Bit i=1 iff digit i and every digit above it are zero, for i ≥ 1.
  - Bit 0 is always 0, so zero displays as "0".
- **Sign on zero:** `neg` is forced to 0 when the magnitude is 0.
- **Ignored inputs:** `in_valid` outside IDLE is ignored. `bin_in` is not sampled after the accept edge.
- **`busy`:** 1 in SHIFT, 0 otherwise.

## Timing
- **Reset values:** state IDLE, shift register 0, counter 0, `bcd_out`=0, `blank_mask`=0, `neg`=0, `out_valid`=0, `busy`=0, `in_ready`=1.
- **Latency:** accept at edge E0; shifts occur on edges E1..E_BIN_W; `out_valid` rises after edge E_BIN_W. That is BIN_W cycles from accept to `out_valid`.
- **Throughput:** at best one result per BIN_W+2 cycles (DONE→IDLE costs one cycle; `in_ready` is low in DONE).
- **Handshake signals:** `in_ready` and `out_valid` are decoded directly from state registers, with no combinational path from `in_valid` or `out_ready`.
- **Backpressure:** `out_ready` low holds DONE and all outputs indefinitely.
- **Result persistence:** `bcd_out` keeps its last value after leaving DONE, until the next result.
- **Reset mid-conversion:** asserting `reset` in SHIFT or DONE returns immediately to reset values. No partial result is ever presented.
- **Counter width:** $clog2(BIN_W+1). The counter does not wrap within a conversion.

## Structure
- **Package `bcd_pkg`:**
  - state enum (IDLE/SHIFT/DONE);
  - constant function `bcd_digits_needed(bin_w, signed)`, used by the elaboration check;
  - nibble width constant (4).
- **Sub-module `bcd_nibble_adj`:** combinational 4-bit "if >4 add 3" corrector, instantiated DIGITS times in a generate loop.
- Control FSM, counter, shift register and blank-mask logic are in the top module.

## Test plan
- **Unsigned full scale:** BIN_W=13, DIGITS=4, accept 8191 → `out_valid` after exactly 13 cycles, `bcd_out`=16'h8191, `blank_mask`=4'b0000, `neg`=0.
- **Small value and zero:** accept 7 → 16'h0007 with mask 4'b1110; then accept 0 → 16'h0000 with mask 4'b1110.
- **Signed mode:** SIGNED=1, BIN_W=8, DIGITS=3. Accept 8'h80 → 12'h128, `neg`=1, mask 3'b000. Accept 8'hFF → 12'h001, `neg`=1, mask 3'b110.
- **Backpressure and ignored input:**
  - Hold `out_ready`=0 for 20 cycles with `in_valid`=1 and a changing `bin_in` → outputs unchanged, `in_ready`=0.
  - Release `out_ready` → one cycle later `in_ready`=1 and the next accepted value converts correctly.
- **Reset mid-shift:** drive `reset` low at shift 5 of 13 → all outputs take reset values at once. After release, accepting 1234 gives 16'h1234.
- **Back-to-back stream:** `out_ready` tied 1, values 0..100 streamed → each result matches the reference model, with spacing of exactly BIN_W+2 cycles.
